// File: rtl/debounce_event_arbiter_pkg.sv
// Shared definitions for the debounce/event arbiter slice: arbiter state
// encoding and the width helper used for counters and channel indices.
package debounce_event_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_e;

    localparam logic [0:0] ST_IDLE    = IDLE;
    localparam logic [0:0] ST_PRESENT = PRESENT;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int widthOf(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_event_arbiter_channel.sv
// One debounce lane: synchronizer, stable-sample counter, debounced level
// and a one-cycle edge pulse that coincides with the level change.
module debounce_channel
    import debounce_event_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_noisy,
    output logic o_level,
    output logic o_edge
);

    localparam int               CNT_W    = widthOf(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_edge;
    logic                   w_sample;

    assign w_sample = r_sync[SYNC_STAGES-1];

    // Any sample that agrees with the current level restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_noisy};
            r_edge <= 1'b0;
            if (i_tick) begin
                if (w_sample == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                    r_edge  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_edge  = r_edge;

endmodule

// File: rtl/debounce_event_arbiter.sv
// Multi-channel debouncer whose level changes are queued in one-deep
// per-channel slots and served round-robin over a valid/ready event port.
module debounce_event_arbiter
    import debounce_event_arbiter_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int no_sync_stages = 2,
    parameter int TICK_DIV       = 4,
    parameter int STABLE_CNT     = 5,
    localparam int CH_W          = widthOf(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] noisy_IN,
    output logic [NUM_CH-1:0] Debouncer_out,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_chan,
    output logic              evt_level,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] clr_ovf
);

    localparam int              PS_W    = widthOf(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0]   r_presc;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_plev;
    logic [NUM_CH-1:0] r_ovf;
    logic [0:0]        r_state;
    logic [CH_W-1:0]   r_ptr;
    logic              r_evtValid;
    logic [CH_W-1:0]   r_evtChan;
    logic              r_evtLevel;

    logic              w_tick;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_clearOh;
    logic              w_found;
    logic [CH_W-1:0]   w_grantIdx;

    // First pending channel at or after ptr, wrapping modulo NUM_CH.
    function automatic logic [CH_W:0] pickNext(input logic [NUM_CH-1:0] pend,
                                               input logic [CH_W-1:0]   ptr);
        logic [CH_W:0]   result;
        logic [CH_W-1:0] sel;
        int              idx;
        result = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            sel = CH_W'(idx);
            if (pend[sel]) result = {1'b1, sel};
        end
        return result;
    endfunction

    assign w_tick = (r_presc == PS_LAST);

    always_ff @(posedge CLK) begin
        if (RST || w_tick) r_presc <= '0;
        else               r_presc <= r_presc + 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES(no_sync_stages),
            .STABLE_CNT (STABLE_CNT)
        ) u_ch (
            .i_clk  (CLK),
            .i_rst  (RST),
            .i_tick (w_tick),
            .i_noisy(noisy_IN[g]),
            .o_level(w_level[g]),
            .o_edge (w_edge[g])
        );
    end

    assign {w_found, w_grantIdx} = pickNext(r_pend, r_ptr);

    always_comb begin
        w_clearOh = '0;
        if (r_state == ST_IDLE && w_found) w_clearOh[w_grantIdx] = 1'b1;
    end

    // A fresh edge always wins over the grant clearing its slot; overflow only
    // counts when the slot still held an unserved event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend <= '0;
            r_plev <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clearOh) | w_edge;
            r_plev <= (r_plev & ~w_edge) | (w_level & w_edge);
            r_ovf  <= (r_ovf & ~clr_ovf) | (w_edge & r_pend & ~w_clearOh);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_evtValid <= 1'b0;
            r_evtChan  <= '0;
            r_evtLevel <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_evtChan  <= w_grantIdx;
                        r_evtLevel <= r_plev[w_grantIdx];
                        r_evtValid <= 1'b1;
                        r_state    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (evt_ready) begin
                        r_evtValid <= 1'b0;
                        r_ptr      <= (r_evtChan == CH_W'(NUM_CH - 1)) ? '0 : r_evtChan + 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Debouncer_out = w_level;
    assign evt_valid     = r_evtValid;
    assign evt_chan      = r_evtChan;
    assign evt_level     = r_evtLevel;
    assign ovf           = r_ovf;

endmodule

// File: doc/debounce_event_arbiter.md
Name: debounce_event_arbiter

Overview:
- Multi-channel debounce controller. Debounces NUM_CH asynchronous noisy inputs (buttons, switches) using one shared sample-tick prescaler.
- Each debounced edge becomes an event. Events from all channels share a single valid/ready event port through a round-robin arbiter.
- Sits between board-level inputs and the control FSMs or register block that consume press/release events.

Parameters:
- NUM_CH, 4: number of input channels (2..16).
- no_sync_stages, 2: flip-flop synchronizer depth per channel (>=2).
- TICK_DIV, 4: clock cycles per sample tick (>=2).
- STABLE_CNT, 5: consecutive differing samples required to accept a new level (>=2).
- CH_W, $clog2(NUM_CH): channel index width (derived, not overridden).

Ports:
- CLK in 1: clock.
- RST in 1: reset. Synchronous, active-high.
- noisy_IN in NUM_CH: asynchronous raw inputs.
- Debouncer_out out NUM_CH: debounced levels.
- evt_valid out 1: event present.
- evt_ready in 1: consumer accepts event.
- evt_chan out CH_W: channel of the presented event.
- evt_level out 1: new debounced level (1 = press, 0 = release).
- ovf out NUM_CH: sticky per-channel event-loss flags.
- clr_ovf in NUM_CH: one-cycle pulse clears the matching ovf bits.

Behaviour:
- Reset: with RST=1 at a CLK edge, all registers clear. Synchronizers, prescaler, per-channel counters, pending bits, Debouncer_out, evt_valid, evt_chan, evt_level, ovf and the round-robin pointer all go to 0. FSM goes to IDLE. Reset mid-operation drops any presented or pending event without handshake.
- Synchronizer: noisy_IN[i] passes through no_sync_stages flops to give s[i]. There is no other path from noisy_IN.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = (count == TICK_DIV-1), one cycle wide. All channels sample on the same tick.
- Per-channel counter (width $clog2(STABLE_CNT)), updated on tick only:
  - s[i] == Debouncer_out[i]: cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - When cnt == STABLE_CNT-1 and s[i] still differs: Debouncer_out[i] toggles next cycle, cnt <= 0, and edge[i] pulses for one cycle.
  - Any matching sample resets the count, so glitches shorter than STABLE_CNT ticks never propagate.
- Latency: from noisy_IN stable, Debouncer_out changes after no_sync_stages + (STABLE_CNT-1)*TICK_DIV + 1 to no_sync_stages + STABLE_CNT*TICK_DIV + 1 cycles.
- Pending slot (one per channel): edge[i] sets pend[i] and stores plev[i] = new level.
  - If pend[i] is already set: plev[i] is overwritten and ovf[i] is set.
  - Set of ovf[i] wins over a simultaneous clr_ovf[i].
- Arbiter FSM:
  - IDLE: if any pend bit is set, grant the first set index searching upward from ptr with wrap. Load evt_chan/evt_level, clear that pend bit, set evt_valid=1, go to PRESENT. An edge arriving on the granted channel in the same cycle re-sets pend with no ovf.
  - PRESENT: evt_valid, evt_chan and evt_level hold stable until evt_valid && evt_ready. On handshake: evt_valid <= 0, ptr <= (evt_chan+1) mod NUM_CH, go to IDLE.
  - This gives a one-cycle bubble between events, so maximum throughput is one event per 2 cycles.
  - evt_ready while in IDLE is ignored.
- Arithmetic: counters saturate never, wrap only as stated. ptr wraps modulo NUM_CH, including non-power-of-2 values.

Decomposition:
- Shared package: FSM state enum (IDLE, PRESENT) and the clog2-based width helper.
- One sub-module, debounce_channel. It holds the per-channel synchronizer, stable counter, Debouncer_out bit and edge pulse. It is instantiated NUM_CH times by generate.
- Prescaler, pending slots, ovf and arbiter stay in the top level.

Test Plan (defaults: NUM_CH=4, no_sync_stages=2, TICK_DIV=4, STABLE_CNT=5):
1. Assert RST=1 for 2 cycles while toggling noisy_IN -> Debouncer_out=0, evt_valid=0, ovf=0 every cycle; after release, nothing changes while noisy_IN=0.
2. noisy_IN[0] 0->1 and held, evt_ready=1 -> Debouncer_out[0] rises 19..23 cycles later. Exactly one event is presented: chan=0, level=1, evt_valid high 1 cycle.
3. Bounce burst on ch1 (1 for 12 cycles, 0 for 3, 1 for 9, then 0) -> Debouncer_out[1] stays 0, no event, ovf=0.
4. ch0, ch2, ch3 rise in the same cycle, ptr=1, evt_ready=1 -> events in order ch2, ch3, ch0, all level=1, each followed by a 1-cycle bubble.
5. evt_ready=0. Step 1: ch1 rises -> presented (1,1) and held. Step 2: ch1 falls -> pending. Step 3: ch1 rises again -> ovf[1]=1. Then set evt_ready=1 -> events (1,1) then (1,1). clr_ovf[1] pulse -> ovf[1]=0.
6. Assert RST for 1 cycle while evt_valid=1 and another channel is pending -> next cycle evt_valid=0 and pend cleared. No event appears afterwards, and Debouncer_out=0 until inputs re-debounce.
